branch_resolve: RTL and testbench
=================================

# branch_resolve

Parametrised branch-decision unit for the multi-cycle datapath. It keeps its own phase counter, samples the branch control signal and ALU flags once per instruction at a configurable phase, and evaluates all six RISC-V branch conditions. It registers the taken decision and the selected next PC for the PC-update stage. It replaces the fixed beq-only AND gate that sampled at phase 4 of 10.

## Interface
Parameters:
- PHASES, 10, cycles per instruction; legal values ≥ 2.
- SAMPLE_PHASE, 4, phase at which the decision is sampled; must be < PHASES.
- PC_WIDTH, 32, width of PC and target buses.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freezes phase counter and sampling while high.
- branch  in  1  control unit: current instruction is a conditional branch.
- funct3  in  3  branch condition select.
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  signed rs1 < rs2.
- alu_ltu  in  1  unsigned rs1 < rs2.
- pc_current  in  PC_WIDTH  PC of the current instruction.
- branch_target  in  PC_WIDTH  computed branch target.
- phase  out  $clog2(PHASES)  current phase counter value.
- take_branch  out  1  registered decision.
- next_pc  out  PC_WIDTH  registered next PC.
- decision_valid  out  1  one-cycle pulse when take_branch/next_pc are updated.
- illegal_cond  out  1  registered: branch=1 with reserved funct3.
- branch_count  out  CNT_WIDTH  sampled branches (statistics).
- taken_count  out  CNT_WIDTH  taken branches (statistics).

## Operation
- Phase counter: 0 after reset. Increments by 1 each cycle with stall=0. Wraps PHASES-1 → 0. Holds while stall=1.
- Sample event: phase==SAMPLE_PHASE and stall=0.
- Condition by funct3:
  - 000 beq: alu_zero
  - 001 bne: !alu_zero
  - 100 blt: alu_lt
  - 101 bge: !alu_lt
  - 110 bltu: alu_ltu
  - 111 bgeu: !alu_ltu
  - 010/011: reserved, condition = 0.
- At a sample event the following registers update:
  - take_branch ← branch & cond.
  - next_pc ← take_branch_new ? branch_target : pc_current + 4. The add is modulo 2^PC_WIDTH, so the carry-out is discarded.
  - illegal_cond ← branch & (funct3 ∈ {010, 011}).
  - decision_valid ← 1.
- decision_valid is 0 on every non-sample cycle. take_branch, next_pc and illegal_cond hold between sample events.
- branch=0 at a sample event: take_branch=0, next_pc=pc_current+4, illegal_cond=0.

## Timing
- Reset values: phase=0, take_branch=0, next_pc=0, decision_valid=0, illegal_cond=0, branch_count=0, taken_count=0.
- Latency: inputs sampled on the edge ending phase SAMPLE_PHASE. Outputs valid in the following cycle, which is phase SAMPLE_PHASE+1, or 0 on wrap.
- Stall at the sample phase: no sample and no pulse. The sample occurs on the first cycle stall drops, using the inputs present in that cycle.
- Reset mid-instruction: reset has priority over stall and sampling. All state clears on that edge and the next instruction starts at phase 0.
- No combinational path from inputs to outputs.

## Configuration
- BRANCH_RESOLVE_STATS_EN defined:
  - At each sample event with branch=1, branch_count increments.
  - taken_count also increments if the branch is taken.
  - Both counters saturate at 2^CNT_WIDTH−1.
  - Both clear on reset.
- BRANCH_RESOLVE_STATS_EN not defined:
  - Counter logic is omitted.
  - branch_count and taken_count are driven constant 0. The ports remain.

## Test plan
- Reset, then 25 cycles with stall=0: phase runs 0..9, 0..9, 0..4. decision_valid pulses at phase 5 of each instruction.
- beq at phase 4 with alu_zero=1, pc_current=0x100, branch_target=0x180: at phase 5, take_branch=1 and next_pc=0x180. Repeat with alu_zero=0: take_branch=0, next_pc=0x104.
- Sweep funct3 over all 8 codes × (alu_lt, alu_ltu, alu_zero) combinations: take_branch matches the condition list. Codes 010 and 011 give take_branch=0 and illegal_cond=1.
- stall=1 held at phase 4 for 3 cycles: phase stays 4 and there is no pulse. Change alu_zero during the stall, then release: the decision uses the value present on the release cycle and the pulse occurs on the next cycle.
- pc_current=0xFFFFFFFC, not taken: next_pc=0x00000000.
- With BRANCH_RESOLVE_STATS_EN and CNT_WIDTH=4: 20 taken branches give branch_count=taken_count=15, saturated. Without the macro both counters read 0. Reset asserted at phase 7 clears all outputs on the next edge.

Source files
------------

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - multi-cycle branch decision unit with phase counter
//
// Purpose: tracks the instruction phase, samples the branch control and ALU
// flags once per instruction at SAMPLE_PHASE, evaluates the six RISC-V branch
// conditions and registers the taken decision and the next PC.
//
// Optional feature macro: BRANCH_RESOLVE_STATS_EN (saturating branch/taken
// statistics counters; when undefined the counter ports read constant 0).
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset
//   stall          in   freezes phase counter and sampling
//   branch         in   current instruction is a conditional branch
//   funct3         in   branch condition select
//   alu_zero       in   rs1 - rs2 == 0
//   alu_lt         in   signed rs1 < rs2
//   alu_ltu        in   unsigned rs1 < rs2
//   pc_current     in   PC of the current instruction
//   branch_target  in   computed branch target
//   phase          out  current phase counter value
//   take_branch    out  registered decision
//   next_pc        out  registered next PC
//   decision_valid out  one-cycle pulse after each sample
//   illegal_cond   out  registered: branch with reserved funct3
//   branch_count   out  sampled branches
//   taken_count    out  taken branches

module branch_resolve #(
    parameter int PHASES       = 10,
    parameter int SAMPLE_PHASE = 4,
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        branch,
    input  logic [2:0]                  funct3,
    input  logic                        alu_zero,
    input  logic                        alu_lt,
    input  logic                        alu_ltu,
    input  logic [PC_WIDTH-1:0]         pc_current,
    input  logic [PC_WIDTH-1:0]         branch_target,
    output logic [$clog2(PHASES)-1:0]   phase,
    output logic                        take_branch,
    output logic [PC_WIDTH-1:0]         next_pc,
    output logic                        decision_valid,
    output logic                        illegal_cond,
    output logic [CNT_WIDTH-1:0]        branch_count,
    output logic [CNT_WIDTH-1:0]        taken_count
);

    localparam int PW = $clog2(PHASES);
    localparam logic [PW-1:0] LAST_PHASE  = PW'(PHASES - 1);
    localparam logic [PW-1:0] SAMPLE_AT   = PW'(SAMPLE_PHASE);

    logic [PW-1:0]       phase_q, phase_d;
    logic                take_q, take_d;
    logic [PC_WIDTH-1:0] npc_q, npc_d;
    logic                valid_q, valid_d;
    logic                illegal_q, illegal_d;

    logic cond;
    logic reserved;
    logic sample;
    logic taken_now;

    always_comb begin
        cond     = 1'b0;
        reserved = 1'b0;
        case (funct3)
            3'b000:  cond = alu_zero;
            3'b001:  cond = !alu_zero;
            3'b100:  cond = alu_lt;
            3'b101:  cond = !alu_lt;
            3'b110:  cond = alu_ltu;
            3'b111:  cond = !alu_ltu;
            default: reserved = 1'b1;
        endcase
    end

    assign sample    = (phase_q == SAMPLE_AT) && !stall;
    assign taken_now = branch & cond;

    always_comb begin
        phase_d   = phase_q;
        take_d    = take_q;
        npc_d     = npc_q;
        illegal_d = illegal_q;
        valid_d   = sample;
        if (!stall) begin
            phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
        end
        if (sample) begin
            take_d    = taken_now;
            // Fall-through add wraps modulo 2^PC_WIDTH.
            npc_d     = taken_now ? branch_target : pc_current + PC_WIDTH'(4);
            illegal_d = branch & reserved;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q   <= '0;
            take_q    <= 1'b0;
            npc_q     <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            take_q    <= take_d;
            npc_q     <= npc_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign phase          = phase_q;
    assign take_branch    = take_q;
    assign next_pc        = npc_q;
    assign decision_valid = valid_q;
    assign illegal_cond   = illegal_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

    always_comb begin
        bcnt_d = bcnt_q;
        tcnt_d = tcnt_q;
        if (sample && branch) begin
            if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_WIDTH'(1);
            if (taken_now && (tcnt_q != '1)) tcnt_d = tcnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bcnt_q <= '0;
            tcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign branch_count = bcnt_q;
    assign taken_count  = tcnt_q;
`else
    assign branch_count = '0;
    assign taken_count  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch;
    logic [2:0]  funct3;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_ltu;
    logic [31:0] pc_current;
    logic [31:0] branch_target;
    logic [3:0]  phase;
    logic        take_branch;
    logic [31:0] next_pc;
    logic        decision_valid;
    logic        illegal_cond;
    logic [3:0]  branch_count;
    logic [3:0]  taken_count;

    int total = 0;
    int bad   = 0;
    int ph    = 0;

    branch_resolve #(
        .PHASES(10), .SAMPLE_PHASE(4), .PC_WIDTH(32), .CNT_WIDTH(4)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .branch(branch),
        .funct3(funct3), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .pc_current(pc_current), .branch_target(branch_target), .phase(phase),
        .take_branch(take_branch), .next_pc(next_pc), .decision_valid(decision_valid),
        .illegal_cond(illegal_cond), .branch_count(branch_count), .taken_count(taken_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
        if (reset) ph = 0;
        else if (!stall) ph = (ph == 9) ? 0 : ph + 1;
    endtask

    task automatic goto_phase(input int p);
        for (int k = 0; k < 20 && ph != p; k++) step();
    endtask

    task automatic do_sample(input logic br, input logic [2:0] f3, input logic z,
                             input logic lt, input logic ltu,
                             input logic [31:0] pc, input logic [31:0] tgt);
        goto_phase(4);
        branch = br; funct3 = f3; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
        pc_current = pc; branch_target = tgt;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; branch = 1'b0; funct3 = 3'b000;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        pc_current = 32'h0; branch_target = 32'h0;
        step(); step();
        reset = 1'b0;
        total++;
        if (phase !== 4'd0 || take_branch !== 1'b0 || next_pc !== 32'h0 ||
            decision_valid !== 1'b0 || illegal_cond !== 1'b0 ||
            branch_count !== 4'd0 || taken_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_state: phase=%0d take=%b npc=%h dv=%b ill=%b bc=%0d tc=%0d expected all zero",
                     phase, take_branch, next_pc, decision_valid, illegal_cond, branch_count, taken_count);
        end
    endtask

    task automatic test_phase_run();
        for (int i = 0; i < 25; i++) begin
            total++;
            if (phase !== 4'(i % 10) || decision_valid !== ((i % 10) == 5)) begin
                bad++;
                $display("FAIL phase_run[%0d]: phase=%0d dv=%b expected phase=%0d dv=%b",
                         i, phase, decision_valid, i % 10, (i % 10) == 5);
            end
            step();
        end
    endtask

    task automatic test_beq();
        do_sample(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h180);
        total++;
        if (phase !== 4'd5 || decision_valid !== 1'b1 || take_branch !== 1'b1 || next_pc !== 32'h180) begin
            bad++;
            $display("FAIL beq_taken: phase=%0d dv=%b take=%b npc=%h expected 5 1 1 00000180",
                     phase, decision_valid, take_branch, next_pc);
        end
        step();
        total++;
        if (decision_valid !== 1'b0 || take_branch !== 1'b1 || next_pc !== 32'h180) begin
            bad++;
            $display("FAIL beq_hold: dv=%b take=%b npc=%h expected 0 1 00000180",
                     decision_valid, take_branch, next_pc);
        end
        do_sample(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h100, 32'h180);
        total++;
        if (decision_valid !== 1'b1 || take_branch !== 1'b0 || next_pc !== 32'h104) begin
            bad++;
            $display("FAIL beq_not_taken: dv=%b take=%b npc=%h expected 1 0 00000104",
                     decision_valid, take_branch, next_pc);
        end
    endtask

    task automatic test_sweep();
        logic exp_take;
        logic exp_ill;
        logic z, lt, ltu;
        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 8; fl++) begin
                z = fl[0]; lt = fl[1]; ltu = fl[2];
                exp_ill = 1'b0;
                case (f)
                    0: exp_take = z;
                    1: exp_take = !z;
                    4: exp_take = lt;
                    5: exp_take = !lt;
                    6: exp_take = ltu;
                    7: exp_take = !ltu;
                    default: begin exp_take = 1'b0; exp_ill = 1'b1; end
                endcase
                do_sample(1'b1, 3'(f), z, lt, ltu, 32'h2000, 32'h3000);
                total++;
                if (decision_valid !== 1'b1 || take_branch !== exp_take || illegal_cond !== exp_ill ||
                    next_pc !== (exp_take ? 32'h3000 : 32'h2004)) begin
                    bad++;
                    $display("FAIL sweep f3=%0d flags=%0d: dv=%b take=%b ill=%b npc=%h expected 1 %b %b %h",
                             f, fl, decision_valid, take_branch, illegal_cond, next_pc,
                             exp_take, exp_ill, exp_take ? 32'h3000 : 32'h2004);
                end
            end
        end
    endtask

    task automatic test_stall();
        goto_phase(4);
        branch = 1'b1; funct3 = 3'b000; alu_zero = 1'b0;
        pc_current = 32'h400; branch_target = 32'h480;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (phase !== 4'd4 || decision_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: phase=%0d dv=%b expected 4 0", i, phase, decision_valid);
            end
        end
        stall = 1'b0; alu_zero = 1'b1;
        step();
        total++;
        if (phase !== 4'd5 || decision_valid !== 1'b1 || take_branch !== 1'b1 || next_pc !== 32'h480) begin
            bad++;
            $display("FAIL stall_release: phase=%0d dv=%b take=%b npc=%h expected 5 1 1 00000480",
                     phase, decision_valid, take_branch, next_pc);
        end
    endtask

    task automatic test_wrap_and_nobranch();
        do_sample(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h10);
        total++;
        if (take_branch !== 1'b0 || next_pc !== 32'h0000_0000) begin
            bad++;
            $display("FAIL pc_wrap: take=%b npc=%h expected 0 00000000", take_branch, next_pc);
        end
        do_sample(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 32'h500, 32'h600);
        do_sample(1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 32'h700, 32'h900);
        total++;
        if (decision_valid !== 1'b1 || take_branch !== 1'b0 || illegal_cond !== 1'b0 || next_pc !== 32'h704) begin
            bad++;
            $display("FAIL no_branch: dv=%b take=%b ill=%b npc=%h expected 1 0 0 00000704",
                     decision_valid, take_branch, illegal_cond, next_pc);
        end
    endtask

    task automatic test_stats();
        reset = 1'b1; step(); reset = 1'b0;
        do_sample(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40);
        do_sample(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
        do_sample(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
        total++;
`ifdef BRANCH_RESOLVE_STATS_EN
        if (branch_count !== 4'd2 || taken_count !== 4'd0) begin
            bad++;
            $display("FAIL stats_partial: bc=%0d tc=%0d expected 2 0", branch_count, taken_count);
        end
`else
        if (branch_count !== 4'd0 || taken_count !== 4'd0) begin
            bad++;
            $display("FAIL stats_partial: bc=%0d tc=%0d expected 0 0", branch_count, taken_count);
        end
`endif
        for (int i = 0; i < 20; i++) do_sample(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
        total++;
`ifdef BRANCH_RESOLVE_STATS_EN
        if (branch_count !== 4'd15 || taken_count !== 4'd15) begin
            bad++;
            $display("FAIL stats_saturate: bc=%0d tc=%0d expected 15 15", branch_count, taken_count);
        end
`else
        if (branch_count !== 4'd0 || taken_count !== 4'd0) begin
            bad++;
            $display("FAIL stats_saturate: bc=%0d tc=%0d expected 0 0", branch_count, taken_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_sample(1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 32'h800, 32'h900);
        total++;
        if (illegal_cond !== 1'b1 || next_pc !== 32'h804) begin
            bad++;
            $display("FAIL pre_reset: ill=%b npc=%h expected 1 00000804", illegal_cond, next_pc);
        end
        goto_phase(7);
        stall = 1'b1;
        reset = 1'b1;
        step();
        total++;
        if (phase !== 4'd0 || take_branch !== 1'b0 || next_pc !== 32'h0 ||
            decision_valid !== 1'b0 || illegal_cond !== 1'b0 ||
            branch_count !== 4'd0 || taken_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: phase=%0d take=%b npc=%h dv=%b ill=%b bc=%0d tc=%0d expected all zero",
                     phase, take_branch, next_pc, decision_valid, illegal_cond, branch_count, taken_count);
        end
        reset = 1'b0; stall = 1'b0;
        step();
        total++;
        if (phase !== 4'd1) begin
            bad++;
            $display("FAIL reset_restart: phase=%0d expected 1", phase);
        end
    endtask

    initial begin
        test_reset();
        test_phase_run();
        test_beq();
        test_sweep();
        test_stall();
        test_wrap_and_nobranch();
        test_stats();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
